// File: rtl/stage_mem.sv
// Memory-access stage: byte-serial loads/stores on an 8-bit memory port,
// load-data extension, upstream stall and write-back register.
module stage_mem #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        func3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              stall_req_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o
);

  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;

  typedef enum logic [1:0] {IDLE, ACCESS, LAST, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [31:0]       ldata_q, ldata_d;
  logic [2:0]        func3_q, func3_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic              store_q, store_d;
  logic              gnt_dly_q, gnt_dly_d;
  logic [4:0]        wb_wd_q, wb_wd_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;

  logic              is_mem;
  logic              gnt;
  logic              last_byte;
  logic [1:0]        lane;
  logic [31:0]       ld_word;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign is_mem      = (opcode_i == L_OP) || (opcode_i == S_OP);
  assign mem_req_o   = (state_q == ACCESS) && rdy;
  assign mem_we_o    = (state_q == ACCESS) && store_q;
  assign mem_addr_o  = base_q + ADDR_W'(idx_q);
  assign mem_wdata_o = sdata_q[{idx_q[1:0], 3'b000} +: 8];
  assign stall_req_o = ((state_q == IDLE) && is_mem) || (state_q == ACCESS) || (state_q == LAST);
  assign wd_o        = wb_wd_q;
  assign wreg_o      = wb_wreg_q;
  assign wdata_o     = wb_wdata_q;

  assign gnt       = mem_req_o && mem_gnt_i;
  assign last_byte = (idx_q == (cnt_q - 3'd1));
  assign lane      = 2'(idx_q - 3'd1);

  // Read byte arrives one cycle after its grant, when idx already points past it.
  always_comb begin
    ld_word = ldata_q;
    if (gnt_dly_q) ld_word[{lane, 3'b000} +: 8] = mem_rdata_i;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    sdata_d    = sdata_q;
    ldata_d    = ldata_q;
    func3_d    = func3_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    wreg_d     = wreg_q;
    store_d    = store_q;
    gnt_dly_d  = gnt_dly_q;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    wb_wdata_d = wb_wdata_q;
    if (rdy) begin
      gnt_dly_d = gnt && !store_q;
      ldata_d   = ld_word;
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            base_d     = mem_addr_i[ADDR_W-1:0];
            sdata_d    = wdata_i;
            func3_d    = func3_i;
            wd_d       = wd_i;
            wreg_d     = wreg_i;
            store_d    = (opcode_i == S_OP);
            idx_d      = '0;
            case (func3_i[1:0])
              2'b00:   cnt_d = 3'd1;
              2'b01:   cnt_d = 3'd2;
              default: cnt_d = 3'd4;
            endcase
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
            state_d    = ACCESS;
          end else begin
            wb_wd_d    = wd_i;
            wb_wreg_d  = wreg_i;
            wb_wdata_d = wdata_i;
          end
        end
        ACCESS: begin
          if (gnt) begin
            idx_d = idx_q + 3'd1;
            if (last_byte) begin
              if (store_q) begin
                wb_wd_d    = wd_q;
                wb_wreg_d  = 1'b0;
                wb_wdata_d = '0;
                state_d    = DONE;
              end else begin
                state_d = LAST;
              end
            end
          end
        end
        LAST: begin
          wb_wd_d    = wd_q;
          wb_wreg_d  = wreg_q;
          wb_wdata_d = extend(func3_q, ld_word);
          state_d    = DONE;
        end
        DONE: begin
          wb_wd_d    = '0;
          wb_wreg_d  = 1'b0;
          wb_wdata_d = '0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      sdata_q    <= '0;
      ldata_q    <= '0;
      func3_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      store_q    <= 1'b0;
      gnt_dly_q  <= 1'b0;
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      sdata_q    <= sdata_d;
      ldata_q    <= ldata_d;
      func3_q    <= func3_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      store_q    <= store_d;
      gnt_dly_q  <= gnt_dly_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: vector table plus hand sequences for
// grant back-pressure, rdy freeze, reset mid-access and back-to-back ALU ops.
module tb_stage_mem;

  localparam logic [6:0] L_OP   = 7'b0000011;
  localparam logic [6:0] S_OP   = 7'b0100011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam int unsigned NV    = 13;
  localparam int unsigned LOG_N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic [6:0]  opcode_i;
  logic [2:0]  func3_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i = 8'h00;
  logic        stall_req_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        gnt_en = 1'b1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] lg_addr [LOG_N];
  logic        lg_we   [LOG_N];
  logic [7:0]  lg_wd   [LOG_N];
  int unsigned gcnt = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] din;
    logic [31:0] pre;
    int unsigned n;
    int unsigned stall;
    logic [31:0] exp;
    logic        exp_wreg;
  } vec_t;

  vec_t vecs [NV];

  stage_mem #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .opcode_i(opcode_i), .func3_i(func3_i), .mem_addr_i(mem_addr_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;
  assign mem_gnt_i = gnt_en;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Byte memory: read data valid the cycle after the grant, held otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) begin
      lg_addr[gcnt % LOG_N] = mem_addr_o;
      lg_we[gcnt % LOG_N]   = mem_we_o;
      lg_wd[gcnt % LOG_N]   = mem_wdata_o;
      gcnt = gcnt + 1;
      if (!mem_we_o) mem_rdata_i <= rd_byte(mem_addr_o);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [4:0] wd, input logic wr, input logic [31:0] d);
    opcode_i = op; func3_i = f3; mem_addr_i = a; wd_i = wd; wreg_i = wr; wdata_i = d;
  endtask

  task automatic drive_nop();
    drive(R_OP, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  task automatic wait_done(input string nm, output int unsigned cyc);
    cyc = 0;
    @(negedge clk);
    while (stall_req_o && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 50) chk({nm, "_timeout"}, 32'(cyc), 32'd0);
  endtask

  task automatic run_vec(input int unsigned k);
    vec_t v;
    logic [7:0] db;
    bit is_mem, st;
    int unsigned cyc, base;
    string nm;
    v = vecs[k];
    nm = $sformatf("vec%0d", k);
    is_mem = (v.op == L_OP) || (v.op == S_OP);
    st = (v.op == S_OP);
    for (int unsigned j = 0; j < 4; j++) mem[v.addr + 32'(j)] = v.pre[8*j +: 8];
    @(posedge clk); #1;
    drive(v.op, v.f3, v.addr, v.wd, v.wreg, v.din);
    base = gcnt;
    if (!is_mem) begin
      @(negedge clk);
      chk({nm, "_stall"}, 32'(stall_req_o), 32'd0);
      @(posedge clk); #1 drive_nop();
      @(negedge clk);
      chk({nm, "_wdata"}, wdata_o, v.exp);
      chk({nm, "_wd"}, 32'(wd_o), 32'(v.wd));
      chk({nm, "_wreg"}, 32'(wreg_o), 32'(v.exp_wreg));
    end else begin
      wait_done(nm, cyc);
      chk({nm, "_latency"}, 32'(cyc), 32'(v.stall));
      chk({nm, "_wdata"}, wdata_o, v.exp);
      chk({nm, "_wreg"}, 32'(wreg_o), 32'(v.exp_wreg));
      if (!st) chk({nm, "_wd"}, 32'(wd_o), 32'(v.wd));
      chk({nm, "_grants"}, gcnt - base, 32'(v.n));
      for (int unsigned j = 0; j < v.n; j++) begin
        chk($sformatf("%s_addr%0d", nm, j), lg_addr[(base + j) % LOG_N], v.addr + 32'(j));
        chk($sformatf("%s_we%0d", nm, j), 32'(lg_we[(base + j) % LOG_N]), 32'(st));
        if (st) begin
          db = v.din[8*j +: 8];
          chk($sformatf("%s_sbyte%0d", nm, j), 32'(lg_wd[(base + j) % LOG_N]), 32'(db));
        end
      end
      @(posedge clk); #1 drive_nop();
      @(negedge clk);
      chk({nm, "_wreg_after_done"}, 32'(wreg_o), 32'd0);
    end
  endtask

  initial begin
    int unsigned cyc, base;

    //          op    f3      addr          wd  wr   din           pre           n  stall exp           wreg
    vecs[0]  = '{L_OP, 3'b010, 32'h00001000, 5, 1'b1, 32'h0,        32'h12345678, 4, 6, 32'h12345678, 1'b1};
    vecs[1]  = '{L_OP, 3'b000, 32'h00000080, 6, 1'b1, 32'h0,        32'h00000080, 1, 3, 32'hFFFFFF80, 1'b1};
    vecs[2]  = '{L_OP, 3'b100, 32'h00000080, 7, 1'b1, 32'h0,        32'h00000080, 1, 3, 32'h00000080, 1'b1};
    vecs[3]  = '{L_OP, 3'b001, 32'h00008001, 8, 1'b1, 32'h0,        32'h00007FFF, 2, 4, 32'h00007FFF, 1'b1};
    vecs[4]  = '{L_OP, 3'b001, 32'h00008011, 9, 1'b1, 32'h0,        32'h00008000, 2, 4, 32'hFFFF8000, 1'b1};
    vecs[5]  = '{L_OP, 3'b101, 32'h00008021, 10, 1'b1, 32'h0,       32'h00008000, 2, 4, 32'h00008000, 1'b1};
    vecs[6]  = '{L_OP, 3'b011, 32'h00000040, 11, 1'b1, 32'h0,       32'h04030201, 4, 6, 32'h04030201, 1'b1};
    vecs[7]  = '{L_OP, 3'b010, 32'hFFFFFFFE, 12, 1'b1, 32'h0,       32'hDDCCBBAA, 4, 6, 32'hDDCCBBAA, 1'b1};
    vecs[8]  = '{S_OP, 3'b001, 32'h00002001, 13, 1'b1, 32'h0000ABCD, 32'h0,        2, 3, 32'h0,        1'b0};
    vecs[9]  = '{S_OP, 3'b010, 32'h00003003, 14, 1'b1, 32'hCAFEBABE, 32'h0,        4, 5, 32'h0,        1'b0};
    vecs[10] = '{S_OP, 3'b000, 32'h00005000, 15, 1'b0, 32'h000000EE, 32'h0,        1, 2, 32'h0,        1'b0};
    vecs[11] = '{I_OP, 3'b000, 32'h0,        3, 1'b1, 32'h00000005, 32'h0,        0, 0, 32'h00000005, 1'b1};
    vecs[12] = '{L_OP, 3'b010, 32'h00001000, 16, 1'b0, 32'h0,       32'h12345678, 4, 6, 32'h12345678, 1'b0};

    drive_nop();
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wd", 32'(wd_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int unsigned k = 0; k < NV; k++) run_vec(k);

    // Grant withheld for three edges after the first byte of a LW.
    @(posedge clk); #1 drive(L_OP, 3'b010, 32'h1000, 5'd5, 1'b1, 32'h0);
    base = gcnt;
    @(posedge clk);
    @(posedge clk); #1 gnt_en = 1'b0;
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("gnt_hold_req", 32'(mem_req_o), 32'd1);
      chk("gnt_hold_addr", mem_addr_o, 32'h1001);
      chk("gnt_hold_stall", 32'(stall_req_o), 32'd1);
      @(posedge clk);
    end
    #1 gnt_en = 1'b1;
    wait_done("gnt_hold", cyc);
    chk("gnt_hold_wdata", wdata_o, 32'h12345678);
    chk("gnt_hold_wreg", 32'(wreg_o), 32'd1);
    chk("gnt_hold_grants", gcnt - base, 32'd4);

    // rdy low for two cycles mid-load.
    @(posedge clk); #1 drive(L_OP, 3'b010, 32'h1000, 5'd5, 1'b1, 32'h0);
    base = gcnt;
    @(posedge clk);
    @(posedge clk); #1 rdy = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rdy0_req", 32'(mem_req_o), 32'd0);
      chk("rdy0_addr", mem_addr_o, 32'h1001);
      chk("rdy0_stall", 32'(stall_req_o), 32'd1);
      @(posedge clk);
    end
    #1 rdy = 1'b1;
    wait_done("rdy0", cyc);
    chk("rdy0_wdata", wdata_o, 32'h12345678);
    chk("rdy0_grants", gcnt - base, 32'd4);

    // Reset pulse while the second byte of a LW is requested.
    @(posedge clk); #1 drive(L_OP, 3'b010, 32'h1000, 5'd5, 1'b1, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_pre_addr", mem_addr_o, 32'h1001);
    rst_n = 1'b0;
    drive_nop();
    #1;
    chk("rstmid_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_stall", 32'(stall_req_o), 32'd0);
    chk("rstmid_addr", mem_addr_o, 32'd0);
    chk("rstmid_wdata", wdata_o, 32'd0);
    chk("rstmid_wreg", 32'(wreg_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_idle_req", 32'(mem_req_o), 32'd0);
    run_vec(0);

    // Back-to-back ALU results.
    @(posedge clk); #1 drive(I_OP, 3'b000, 32'h0, 5'd3, 1'b1, 32'd5);
    @(negedge clk);
    chk("b2b_stall0", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1 drive(R_OP, 3'b000, 32'h0, 5'd7, 1'b1, 32'd9);
    @(negedge clk);
    chk("b2b_wdata0", wdata_o, 32'd5);
    chk("b2b_wd0", 32'(wd_o), 32'd3);
    chk("b2b_stall1", 32'(stall_req_o), 32'd0);
    @(posedge clk); #1 drive_nop();
    @(negedge clk);
    chk("b2b_wdata1", wdata_o, 32'd9);
    chk("b2b_wd1", 32'(wd_o), 32'd7);
    chk("b2b_stall2", 32'(stall_req_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
